// File: rtl/scan_sel_gen_pkg.sv
// Shared definitions for the digit scan controller: FSM encoding, digit count
// and a lowest-set-bit helper used for both the start digit and the wrap search.
package scan_sel_gen_pkg;

    localparam int NUM_DIG = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    function automatic logic [2:0] first_set(input logic [NUM_DIG-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_sel_gen_next_sel_pick.sv
// Combinational next-digit search: first enabled digit strictly above sel,
// wrapping to the lowest enabled one; wrap flags that the frame restarts.
module next_sel_pick
    import scan_sel_gen_pkg::*;
(
    input  logic [2:0]         sel,
    input  logic [NUM_DIG-1:0] mask,
    output logic [2:0]         nxt,
    output logic               wrap
);

    logic [3:0]           sh;
    logic [2*NUM_DIG-1:0] dbl;
    logic [NUM_DIG-1:0]   rot;
    logic [2:0]           ofs;

    // Rotating by sel+1 puts the digit just above sel at bit 0, so a single
    // bit of sel itself lands at bit 7 and the search returns sel with wrap set.
    always_comb begin
        sh   = {1'b0, sel} + 4'd1;
        dbl  = {mask, mask};
        rot  = dbl[sh +: NUM_DIG];
        ofs  = first_set(rot);
        nxt  = sel + ofs + 3'd1;
        wrap = (mask != '0) && (nxt <= sel);
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Digit scan controller feeding a 3-to-8 decoder: per-slot blanking then show,
// masked digits skipped, and a double-buffered data word swapped at frame wrap.
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [NUM_DIG-1:0] digit_mask,
    input  logic [31:0]        data_in,
    input  logic               load,
    output logic [2:0]         sel,
    output logic               en,
    output logic [3:0]         nibble,
    output logic               frame_done
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         sel_d;
    logic               en_d, fd_d;
    logic [3:0]         nibble_d;
    logic [31:0]        pending, pending_d;
    logic [31:0]        shadow, shadow_d;
    logic               pvld, pvld_d;
    logic [2:0]         nxt;
    logic               wrap;

    next_sel_pick u_pick (
        .sel  (sel),
        .mask (digit_mask),
        .nxt  (nxt),
        .wrap (wrap)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sel_d     = sel;
        en_d      = en;
        fd_d      = 1'b0;
        pending_d = pending;
        shadow_d  = shadow;
        pvld_d    = pvld;

        // While idle there is no frame in flight, so loads go straight to the display.
        if (load) begin
            pending_d = data_in;
            if (state == ST_IDLE) begin
                shadow_d = data_in;
                pvld_d   = 1'b0;
            end else begin
                pvld_d   = 1'b1;
            end
        end

        if (!run) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            en_d    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_d = '0;
                    en_d  = 1'b0;
                    if (digit_mask != '0) begin
                        sel_d   = first_set(digit_mask);
                        state_d = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    en_d  = 1'b0;
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        state_d = ST_SHOW;
                        en_d    = 1'b1;
                    end
                end
                ST_SHOW: begin
                    en_d  = 1'b1;
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SLOT_CYC - 1)) begin
                        cnt_d = '0;
                        en_d  = 1'b0;
                        if (digit_mask == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BLANK;
                            sel_d   = nxt;
                            if (wrap) begin
                                fd_d = 1'b1;
                                // Old pending wins; a load on this edge waits a frame.
                                if (pvld) begin
                                    shadow_d = pending;
                                    pvld_d   = load;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            endcase
        end

        nibble_d = shadow_d[{sel_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= '0;
            en         <= 1'b0;
            nibble     <= '0;
            frame_done <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
            pvld       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel        <= sel_d;
            en         <= en_d;
            nibble     <= nibble_d;
            frame_done <= fd_d;
            pending    <= pending_d;
            shadow     <= shadow_d;
            pvld       <= pvld_d;
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen with a short slot (8 cycles, 2 blanking).
module tb_scan_sel_gen;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  digit_mask;
    logic [31:0] data_in;
    logic        load;
    logic [2:0]  sel;
    logic        en;
    logic [3:0]  nibble;
    logic        frame_done;

    int total;
    int bad;

    scan_sel_gen #(
        .SLOT_CYC  (SLOT),
        .BLANK_CYC (BLANK),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .digit_mask (digit_mask),
        .data_in    (data_in),
        .load       (load),
        .sel        (sel),
        .en         (en),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full slot: blank for BLANK cycles, show for the rest, optional load pulse.
    task automatic scan_slot(input logic [2:0] s, input logic [3:0] nb, input logic fd,
                             input int ld_at, input logic [31:0] ld_val);
        for (int c = 0; c < SLOT; c++) begin
            if (c == ld_at) begin
                data_in = ld_val;
                load    = 1'b1;
            end
            tick();
            load = 1'b0;
            chk("sel", 32'(sel), 32'(s));
            chk("en", 32'(en), 32'(c >= BLANK));
            chk("nibble", 32'(nibble), 32'(nb));
            chk("frame_done", 32'(frame_done), (c == 0) ? 32'(fd) : 32'd0);
        end
    endtask

    // Break-before-make: en high only when sel matches the previous cycle.
    logic [2:0] sel_prev;
    logic       bbm_arm;
    initial bbm_arm = 1'b0;
    always @(negedge clk) begin
        if (rst_n && bbm_arm)
            chk("bbm", 32'(en && (sel != sel_prev)), 32'd0);
        sel_prev <= sel;
        bbm_arm  <= rst_n;
    end

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        run        = 1'b0;
        digit_mask = 8'h00;
        data_in    = 32'h0;
        load       = 1'b0;

        repeat (3) tick();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_nibble", 32'(nibble), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Idle load lands in the shadow at once; run=0 keeps en low.
        data_in = 32'h7654_3210;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        digit_mask = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_en", 32'(en), 32'd0);
            chk("idle_nibble", 32'(nibble), 32'd0);
        end

        // Full mask scan; mid-frame load swaps in at the wrap.
        run = 1'b1;
        for (int s = 0; s < 8; s++) scan_slot(3'(s), 4'(s), 1'b0, -1, 32'h0);
        scan_slot(3'd0, 4'd0, 1'b1, -1, 32'h0);
        scan_slot(3'd1, 4'd1, 1'b0, -1, 32'h0);
        scan_slot(3'd2, 4'd2, 1'b0, 3, 32'hFEDC_BA98);
        for (int s = 3; s < 8; s++) scan_slot(3'(s), 4'(s), 1'b0, -1, 32'h0);
        scan_slot(3'd0, 4'd8, 1'b1, -1, 32'h0);
        scan_slot(3'd1, 4'd9, 1'b0, -1, 32'h0);
        scan_slot(3'd2, 4'd10, 1'b0, 4, 32'h0123_4567);
        for (int s = 3; s < 8; s++) scan_slot(3'(s), 4'(8 + s), 1'b0, -1, 32'h0);
        // Load on the wrap edge: old pending shows now, the new word next frame.
        scan_slot(3'd0, 4'd7, 1'b1, 0, 32'h89AB_CDEF);
        for (int s = 1; s < 8; s++) scan_slot(3'(s), 4'(7 - s), 1'b0, -1, 32'h0);
        scan_slot(3'd0, 4'd15, 1'b1, -1, 32'h0);
        scan_slot(3'd1, 4'd14, 1'b0, -1, 32'h0);

        // Sparse mask 1,4,7 then single digit 2.
        digit_mask = 8'b1001_0010;
        scan_slot(3'd4, 4'd11, 1'b0, -1, 32'h0);
        scan_slot(3'd7, 4'd8, 1'b0, -1, 32'h0);
        scan_slot(3'd1, 4'd14, 1'b1, -1, 32'h0);
        scan_slot(3'd4, 4'd11, 1'b0, -1, 32'h0);
        scan_slot(3'd7, 4'd8, 1'b0, -1, 32'h0);
        digit_mask = 8'b0000_0100;
        for (int k = 0; k < 3; k++) scan_slot(3'd2, 4'd13, 1'b1, -1, 32'h0);

        // Mask cleared mid-show: slot finishes, then idle with no frame_done.
        for (int c = 0; c < SLOT; c++) begin
            if (c == 4) digit_mask = 8'h00;
            tick();
            chk("mz_sel", 32'(sel), 32'd2);
            chk("mz_en", 32'(en), 32'(c >= BLANK));
            chk("mz_fd", 32'(frame_done), (c == 0) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mz_idle_en", 32'(en), 32'd0);
            chk("mz_idle_sel", 32'(sel), 32'd2);
            chk("mz_idle_fd", 32'(frame_done), 32'd0);
        end

        // run dropped mid-show: en falls next edge, sel holds.
        digit_mask = 8'b0010_0000;
        tick();
        chk("r0_sel", 32'(sel), 32'd5);
        chk("r0_nibble", 32'(nibble), 32'd10);
        repeat (3) tick();
        chk("r0_en_show", 32'(en), 32'd1);
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r0_en", 32'(en), 32'd0);
            chk("r0_hold_sel", 32'(sel), 32'd5);
            chk("r0_fd", 32'(frame_done), 32'd0);
        end

        // Asynchronous reset mid-show.
        run = 1'b1;
        repeat (4) tick();
        chk("ar_en_show", 32'(en), 32'd1);
        chk("ar_sel_show", 32'(sel), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_en", 32'(en), 32'd0);
        chk("ar_sel", 32'(sel), 32'd0);
        chk("ar_fd", 32'(frame_done), 32'd0);
        chk("ar_nibble", 32'(nibble), 32'd0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_en", 32'(en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Sequential scan controller that sits directly upstream of the team's 3-to-8 active-low decoder and drives its 3-bit select and enable.
- Steps through up to 8 display digit slots with a programmable dwell time.
- Inserts a blanking interval at the start of each slot (enable low) to suppress ghosting.
- Skips masked-off digits and presents the 4-bit data nibble of the current digit for the segment encoder.

Parameters:
- SLOT_CYC, 50000, clock cycles per digit slot including blanking; legal range ≥ BLANK_CYC+1.
- BLANK_CYC, 16, cycles at slot start with EN low; legal range ≥ 1.
- CNT_W, 16, width of the slot cycle counter; must satisfy 2^CNT_W > SLOT_CYC.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- run, input, 1, level; 1 = scan, 0 = stop and blank.
- digit_mask, input, 8, bit i = 1 means digit i is displayed. Sampled only at slot end.
- data_in, input, 32, nibble i (bits 4i+3:4i) holds the value for digit i.
- load, input, 1, single-cycle pulse; captures data_in into the pending register.
- sel, output, 3, digit index; connects to the decoder DIN.
- en, output, 1, active-high enable; connects to the decoder EN.
- nibble, output, 4, shadow-register nibble for the current sel.
- frame_done, output, 1, one-cycle pulse when the scan wraps.

Behaviour:
- Reset is asynchronous and active-low (rst_n); one clock (clk). Reset values: sel=0, en=0, nibble=0, frame_done=0, state=IDLE, cnt=0, pending=0, shadow=0, pend_valid=0. All outputs are registered.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - en=0 and cnt=0.
  - When run=1 and digit_mask!=0: sel ← lowest set bit of digit_mask, go to BLANK.
  - When run=1 and mask==0: remain in IDLE.
- BLANK:
  - en=0; cnt increments each cycle.
  - When cnt==BLANK_CYC-1: go to SHOW, en←1 on the same edge.
- SHOW:
  - en=1; cnt increments.
  - When cnt==SLOT_CYC-1: cnt←0, en←0, go to BLANK with sel←next.
  - next = the first set bit of digit_mask strictly above sel, wrapping to the lowest set bit.
  - If the mask became 0: go to IDLE.
- Wrap: when the next index is ≤ the current sel (including a single-bit mask), frame_done pulses for exactly one cycle, coincident with the sel update.
- run=0 in any state: next edge goes to IDLE with en=0 and cnt=0. sel holds its value. No frame_done is generated.
- Data path:
  - load=1 → pending←data_in, pend_valid←1.
  - At every wrap edge with pend_valid=1: shadow←pending, pend_valid←0.
  - load coincident with the wrap edge: shadow takes the old pending; the new data stays pending for the next frame.
  - The first load while in IDLE copies to shadow immediately, so data is valid before scanning starts.
- nibble = shadow[4*sel +: 4], registered; it updates on the same edge as sel.
- en must never be 1 on a cycle where sel differs from the previous cycle (break-before-make). SHOW→BLANK drops en on the same edge that sel changes.
- Reset mid-slot: outputs go to reset values immediately, without waiting for clk.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_BLANK=2'd1, ST_SHOW=2'd2;
  - the NUM_DIG=8 constant.
- One sub-module: next_sel_pick. It is combinational: from sel[2:0] and mask[7:0] it gives nxt[2:0] and wrap, using a rotate-and-priority-encode.
- The cycle counter and FSM stay in the top level.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 mid-SHOW → en=0, sel=0, frame_done=0 within the same cycle, before the next clk edge.
  - Hold run=0 → en stays 0.
- Full scan (SLOT_CYC=8, BLANK_CYC=2, mask=8'hFF, run=1):
  - sel steps 0..7 then 0.
  - en low for 2 cycles, then high for 6 cycles, per slot.
  - frame_done pulses once every 64 cycles on the 7→0 edge.
- Sparse mask (mask=8'b1001_0010):
  - sel sequence 1,4,7,1.
  - frame_done on the 7→1 transition.
  - Set mask=8'b0000_0100 → sel stays 2 and frame_done pulses every slot.
- Mask to zero mid-SHOW → slot completes, FSM returns to IDLE, en stays 0, no frame_done.
- Data double-buffering:
  - data_in=32'h7654_3210 with load in IDLE → nibble equals sel.
  - Mid-frame load of 32'hFEDC_BA98 → nibble is unchanged until the wrap edge, then becomes 8+sel.
  - A load on the exact wrap edge defers by one frame.
- Break-before-make monitor across all scenarios: assertion that en==1 implies sel is stable since the prior cycle, with zero failures.
